// File: rtl/conv_inst_sequencer.sv
// conv_inst_sequencer: walks oc_group x ic_group x kij and generates the 64-bit conv-core
// instruction stream. Per kij it loads weights into L0, loads the PE kernel, waits a settle gap,
// then streams activations while popping OFIFO rows into PSUM at the matching output pixel.
module conv_inst_sequencer #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int KSIZE   = 3,
  parameter int IN_W    = 6,
  parameter int N_OC    = 2,
  parameter int N_IC    = 2,
  parameter int W_BASE  = 1024,
  parameter int GAP_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [63:0] inst,
  output logic        busy,
  output logic        done
);

  localparam int KK    = KSIZE * KSIZE;
  localparam int NIJ   = IN_W * IN_W;
  localparam int OUT_W = IN_W - KSIZE + 1;
  localparam int ONIJ  = OUT_W * OUT_W;

  localparam int CW  = 8;
  localparam int PW  = $clog2(NIJ + 1);
  localparam int KW  = $clog2(KK + 1);
  localparam int OCW = (N_OC > 1) ? $clog2(N_OC) : 1;
  localparam int ICW = (N_IC > 1) ? $clog2(N_IC) : 1;

  localparam logic [CW-1:0]  WL_LAST  = CW'(COL);
  localparam logic [CW-1:0]  KL_LAST  = CW'(COL + ROW);
  localparam logic [CW-1:0]  GP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0]  EX_LAST  = CW'(NIJ - 1);
  localparam logic [PW-1:0]  POP_ALL  = PW'(NIJ);
  localparam logic [KW-1:0]  KIJ_LAST = KW'(KK - 1);
  localparam logic [ICW-1:0] IC_LAST  = ICW'(N_IC - 1);
  localparam logic [OCW-1:0] OC_LAST  = OCW'(N_OC - 1);
  localparam logic signed [7:0] OUT_S = 8'(OUT_W);

  // Both memories disabled and xmem write-protected; everything else quiet.
  localparam logic [63:0] IDLE_WORD = 64'h0000_0001_000C_0000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WLOAD = 3'd1;
  localparam logic [2:0] S_KLOAD = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]     state;
  logic [CW-1:0]  cyc;
  logic [PW-1:0]  pops;
  logic [KW-1:0]  kij;
  logic [ICW-1:0] ic;
  logic [OCW-1:0] oc;

  logic              pop;
  logic              pix_ok;
  logic              first_acc;
  logic signed [7:0] ox;
  logic signed [7:0] oy;
  logic [10:0]       w_addr;
  logic [10:0]       x_addr;
  logic [10:0]       p_addr;
  logic [63:0]       word;

  // Build the instruction word for the current state; the pop overlay maps the popped row to its output pixel.
  always_comb begin
    pop       = ((state == S_EXEC) || (state == S_DRAIN)) && ofifo_valid && (pops < POP_ALL);
    ox        = 8'(int'(pops) % IN_W) - 8'(int'(kij) % KSIZE);
    oy        = 8'(int'(pops) / IN_W) - 8'(int'(kij) / KSIZE);
    pix_ok    = (ox >= 8'sd0) && (ox < OUT_S) && (oy >= 8'sd0) && (oy < OUT_S);
    p_addr    = 11'(int'(oc) * ONIJ + int'(oy) * OUT_W + int'(ox));
    w_addr    = 11'(W_BASE + ((int'(oc) * N_IC + int'(ic)) * KK + int'(kij)) * COL + int'(cyc));
    x_addr    = 11'(int'(ic) * NIJ + int'(cyc));
    first_acc = (ic == '0) && (kij == '0);
    word      = IDLE_WORD;
    case (state)
      S_WLOAD: begin
        word[19]   = 1'b0;
        word[2]    = 1'b1;
        word[17:7] = w_addr;
      end
      S_KLOAD: begin
        word[3] = 1'b1;
        word[0] = (cyc != '0);
      end
      S_EXEC: begin
        word[19]   = 1'b0;
        word[3]    = 1'b1;
        word[2]    = 1'b1;
        word[1]    = 1'b1;
        word[17:7] = x_addr;
      end
      default: ;
    endcase
    if (pop) begin
      word[6]  = 1'b1;
      word[34] = first_acc;
      word[33] = !first_acc;
      if (pix_ok) begin
        word[32]    = 1'b0;
        word[31]    = 1'b1;
        word[30:20] = p_addr;
      end
    end
  end

  // Sequence the phases, step the loop counters and register the outgoing word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cyc   <= '0;
      pops  <= '0;
      kij   <= '0;
      ic    <= '0;
      oc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      inst  <= IDLE_WORD;
    end else begin
      inst <= word;
      if (pop) pops <= pops + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WLOAD;
            cyc   <= '0;
            pops  <= '0;
            kij   <= '0;
            ic    <= '0;
            oc    <= '0;
            busy  <= 1'b1;
          end
        end
        S_WLOAD: begin
          if (cyc == WL_LAST) begin
            state <= S_KLOAD;
            cyc   <= '0;
          end else cyc <= cyc + 1'b1;
        end
        S_KLOAD: begin
          if (cyc == KL_LAST) begin
            state <= S_GAP;
            cyc   <= '0;
          end else cyc <= cyc + 1'b1;
        end
        S_GAP: begin
          if (cyc == GP_LAST) begin
            state <= S_EXEC;
            cyc   <= '0;
          end else cyc <= cyc + 1'b1;
        end
        S_EXEC: begin
          if (cyc == EX_LAST) begin
            state <= S_DRAIN;
            cyc   <= '0;
          end else cyc <= cyc + 1'b1;
        end
        S_DRAIN: begin
          if (pops == POP_ALL) state <= S_NEXT;
        end
        S_NEXT: begin
          pops <= '0;
          if (kij != KIJ_LAST) begin
            kij   <= kij + 1'b1;
            state <= S_WLOAD;
          end else begin
            kij <= '0;
            if (ic != IC_LAST) begin
              ic    <= ic + 1'b1;
              state <= S_WLOAD;
            end else begin
              ic <= '0;
              if (oc != OC_LAST) begin
                oc    <= oc + 1'b1;
                state <= S_WLOAD;
              end else begin
                oc    <= '0;
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Bench for conv_inst_sequencer: expected xmem reads and pmem writes are queued when a run is
// started and consumed as the DUT emits them; phase lengths and pop counts are tracked per kij.
module tb_conv_inst_sequencer;

  localparam logic [63:0] IDLE_WORD = 64'h0000_0001_000C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid = 1'b0;
  logic [63:0] inst;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  bit rand_mode  = 1'b0;
  bit mon_en     = 1'b0;
  bit prev_valid = 1'b0;

  logic [63:0] xq[$];
  logic [63:0] pq[$];

  int kl_cnt, gap_cnt, pops_kij, pop_total, wr_cnt, done_cnt;
  bit in_gap, seen_exec;

  conv_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // OFIFO model: row availability changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ofifo_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Queue the full run's expected xmem reads and pmem writes, in issue order.
  task automatic fill_model();
    int ox, oy, addr, wa;
    bit first;
    xq.delete();
    pq.delete();
    kl_cnt = 0; gap_cnt = 0; pops_kij = 0; pop_total = 0; wr_cnt = 0; done_cnt = 0;
    in_gap = 1'b0; seen_exec = 1'b0;
    for (int oc = 0; oc < 2; oc++)
      for (int ic = 0; ic < 2; ic++)
        for (int kij = 0; kij < 9; kij++) begin
          for (int c = 0; c < 9; c++) begin
            wa = 1024 + ((oc * 2 + ic) * 9 + kij) * 8 + c;
            xq.push_back({52'd0, 1'b0, wa[10:0]});
          end
          for (int c = 0; c < 36; c++) begin
            wa = ic * 36 + c;
            xq.push_back({52'd0, 1'b1, wa[10:0]});
          end
          for (int nij = 0; nij < 36; nij++) begin
            ox = nij % 6 - kij % 3;
            oy = nij / 6 - kij / 3;
            if (ox >= 0 && ox < 4 && oy >= 0 && oy < 4) begin
              addr  = oc * 16 + oy * 4 + ox;
              first = (ic == 0) && (kij == 0);
              pq.push_back({50'd0, first, !first, 1'b1, addr[10:0]});
            end
          end
        end
  endtask

  // Observe every emitted word away from the active edge and consume expectations.
  always @(negedge clk) begin : monitor
    logic [63:0] w;
    logic [63:0] e;
    if (mon_en) begin
      w = inst;
      checkOutput("reserved_zero", {w[63:35], w[5:4]}, 64'd0);
      if (done) begin
        done_cnt++;
        checkOutput("busy_at_done", busy, 64'd0);
      end
      if (w[3] && !w[1]) begin
        checkOutput("kload_load", w[0], (kl_cnt != 0));
        kl_cnt++;
      end else if (kl_cnt != 0) begin
        checkOutput("kload_len", kl_cnt, 64'd17);
        kl_cnt  = 0;
        gap_cnt = 0;
        in_gap  = 1'b1;
      end
      if (in_gap) begin
        if (w == IDLE_WORD) gap_cnt++;
        else begin
          checkOutput("gap_len", gap_cnt, 64'd10);
          in_gap = 1'b0;
          if (seen_exec) checkOutput("pops_per_kij", pops_kij, 64'd36);
          pops_kij  = 0;
          seen_exec = 1'b1;
        end
      end
      if (!w[19]) begin
        checkOutput("xmem_ctl", {w[18], w[2]}, 64'd3);
        if (xq.size() != 0) e = xq.pop_front();
        else e = '1;
        checkOutput("xmem_addr", {w[1], w[17:7]}, e);
      end
      if (w[6]) begin
        pop_total++;
        pops_kij++;
        checkOutput("rd_needs_valid", prev_valid, 64'd1);
        if (!w[32]) begin
          wr_cnt++;
          if (pq.size() != 0) e = pq.pop_front();
          else e = '1;
          checkOutput("pmem_write", {w[34], w[33], w[31], w[30:20]}, e);
        end
      end else begin
        checkOutput("nopop_pmem", {w[32], w[31]}, 64'd2);
      end
    end
    prev_valid = ofifo_valid;
  end

  // One complete run: stray starts mid-run and on the done pulse must be ignored.
  task automatic applyStimulus(input bit rnd);
    bit got;
    got       = 1'b0;
    rand_mode = rnd;
    fill_model();
    mon_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("busy_after_start", busy, 64'd1);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 30000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (got) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end else begin
      checkOutput("done_timeout", got, 64'd1);
    end
    repeat (3) @(negedge clk);
    checkOutput("busy_end", busy, 64'd0);
    checkOutput("idle_end", inst, IDLE_WORD);
    mon_en = 1'b0;
    checkOutput("xmem_left", xq.size(), 64'd0);
    checkOutput("pmem_left", pq.size(), 64'd0);
    checkOutput("pmem_writes", wr_cnt, 64'd576);
    checkOutput("pops_total", pop_total, 64'd1296);
    checkOutput("last_kij_pops", pops_kij, 64'd36);
    checkOutput("done_pulses", done_cnt, 64'd1);
  endtask

  // Main sequence: reset, steady run, random-valid run, mid-run reset and rerun.
  initial begin
    bit got;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_inst", inst, IDLE_WORD);
    checkOutput("reset_busy", busy, 64'd0);
    checkOutput("reset_done", done, 64'd0);

    applyStimulus(1'b0);
    applyStimulus(1'b1);

    rand_mode = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (inst[1]) got = 1'b1;
    end
    checkOutput("exec_reached", got, 64'd1);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    checkOutput("midrun_reset_inst", inst, IDLE_WORD);
    checkOutput("midrun_reset_busy", busy, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("post_reset_idle", inst, IDLE_WORD);

    applyStimulus(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
